// File: rtl/trig_vector.sv
// trig_vector: quarter-wave sine/cosine lookup scaled by an unsigned magnitude via shift-and-add
module trig_vector #(
  parameter int    THETA_W  = 6,
  parameter int    LUT_W    = 8,
  parameter int    MAG_W    = 4,
  parameter string LUT_FILE = "sine.lut"
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     start_i,
  input  logic [THETA_W-1:0]       theta_i,
  input  logic [MAG_W-1:0]         mag_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic signed [LUT_W-1:0]  sin_o,
  output logic signed [LUT_W-1:0]  cos_o,
  output logic signed [MAG_W:0]    vx_o,
  output logic signed [MAG_W:0]    vy_o
);
  localparam int N  = 2 ** (THETA_W - 2);
  localparam int KW = THETA_W - 2;
  localparam int AW = LUT_W + MAG_W;
  localparam int CW = MAG_W > 1 ? $clog2(MAG_W) : 1;
  typedef enum logic [1:0] {IDLE, LOOK, MUL} state_t;
  state_t state, state_n;
  logic [LUT_W-2:0] rom [0:N];
  logic [THETA_W-1:0] th;
  logic [MAG_W-1:0] mg;
  logic [CW-1:0] cnt, pos;
  logic signed [AW-1:0] acc_x, acc_y, sum_x, sum_y, ext_c, ext_s;
  function automatic logic [LUT_W-2:0] sine_entry(input int i);
    real x, t, s;
    x = 3.14159265358979 * i / (2.0 * N);
    t = x;
    s = x;
    for (int n = 1; n < 12; n++) begin
      t = -t * x * x / ((2 * n) * (2 * n + 1));
      s = s + t;
    end
    return (LUT_W-1)'($rtoi(s * ((1 << (LUT_W - 1)) - 1) + 0.5));
  endfunction
  for (genvar i = 0; i <= N; i++) begin : g_e
    assign rom[i] = sine_entry(i);
  end
  function automatic logic signed [LUT_W-1:0] sine(input logic [THETA_W-1:0] t);
    logic [KW:0] k;
    logic [LUT_W-1:0] m;
    k = {1'b0, t[KW-1:0]};
    m = {1'b0, t[THETA_W-2] ? rom[(KW+1)'(N) - k] : rom[k]};
    return t[THETA_W-1] ? -$signed(m) : $signed(m);
  endfunction
  assign busy_o = state != IDLE;
  assign pos    = CW'(MAG_W - 1) - cnt;
  assign ext_c  = {{MAG_W{cos_o[LUT_W-1]}}, cos_o};
  assign ext_s  = {{MAG_W{sin_o[LUT_W-1]}}, sin_o};
  always_comb begin
    state_n = state == IDLE ? (start_i ? LOOK : IDLE) : state == LOOK ? MUL : (cnt == '0 ? IDLE : MUL);
    sum_x   = acc_x + (mg[pos] ? ext_c << pos : '0);
    sum_y   = acc_y + (mg[pos] ? ext_s << pos : '0);
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      done_o <= 1'b0;
      th     <= '0;
      mg     <= '0;
      cnt    <= '0;
      sin_o  <= '0;
      cos_o  <= '0;
      vx_o   <= '0;
      vy_o   <= '0;
      acc_x  <= '0;
      acc_y  <= '0;
    end else begin
      state  <= state_n;
      done_o <= state == MUL && cnt == '0;
      if (state == IDLE && start_i) begin
        th <= theta_i;
        mg <= mag_i;
      end
      if (state == LOOK) begin
        sin_o <= sine(th);
        cos_o <= sine(th + THETA_W'(N));
        acc_x <= '0;
        acc_y <= '0;
        cnt   <= CW'(MAG_W - 1);
      end
      if (state == MUL) begin
        acc_x <= sum_x;
        acc_y <= sum_y;
        cnt   <= cnt - 1'b1;
        if (cnt == '0) begin
          vx_o <= (MAG_W+1)'(sum_x >>> (LUT_W - 1));
          vy_o <= (MAG_W+1)'(sum_y >>> (LUT_W - 1));
        end
      end
    end
  end
endmodule

// File: tb/tb_trig_vector.sv
// tb_trig_vector: directed vectors with a done-driven scoreboard monitor
module tb_trig_vector;
  logic CLK = 0, RST_N = 0, start_i = 0;
  logic [5:0] theta_i = '0;
  logic [3:0] mag_i = '0;
  logic busy_o, done_o;
  logic signed [7:0] sin_o, cos_o;
  logic signed [4:0] vx_o, vy_o;
  int checks = 0, errors = 0, cyc = 0, prev = 0;
  bit ok;
  typedef struct {int s; int c; int x; int y; int a;} exp_t;
  exp_t sb[$];
  exp_t e;

  trig_vector #(.THETA_W(6), .LUT_W(8), .MAG_W(4), .LUT_FILE("")) dut (
    .CLK(CLK), .RST_N(RST_N), .start_i(start_i), .theta_i(theta_i), .mag_i(mag_i),
    .busy_o(busy_o), .done_o(done_o), .sin_o(sin_o), .cos_o(cos_o), .vx_o(vx_o), .vy_o(vy_o)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      ok = !busy_o;
    end
    if (!ok) chk("idle_timeout", 1, 0);
  endtask

  task automatic push(input int s, input int c, input int x, input int y);
    sb.push_back('{s: s, c: c, x: x, y: y, a: cyc + 1});
  endtask

  task automatic issue(input logic [5:0] th, input logic [3:0] mg, input int s, input int c, input int x, input int y);
    wait_idle();
    start_i = 1;
    theta_i = th;
    mag_i = mg;
    push(s, c, x, y);
    @(posedge CLK);
    #1;
    start_i = 0;
    theta_i = th ^ 6'h2A;
    mag_i = ~mg;
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_busy"}, int'(busy_o), 0);
    chk({n, "_done"}, int'(done_o), 0);
    chk({n, "_sin"}, sin_o, 0);
    chk({n, "_cos"}, cos_o, 0);
    chk({n, "_vx"}, vx_o, 0);
    chk({n, "_vy"}, vy_o, 0);
  endtask

  initial forever begin
    @(negedge CLK);
    if (done_o) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sin", sin_o, e.s);
        chk("cos", cos_o, e.c);
        chk("vx", vx_o, e.x);
        chk("vy", vy_o, e.y);
        chk("latency", cyc, e.a + 5);
      end
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST_N = 1;
    issue(6'd0, 4'd15, 0, 127, 14, 0);
    issue(6'd32, 4'd15, 0, -127, -15, 0);
    issue(6'd8, 4'd8, 90, 90, 5, 5);
    issue(6'd48, 4'd15, -127, 0, 0, -15);
    issue(6'd20, 4'd0, 117, -49, 0, 0);
    issue(6'd63, 4'd15, -12, 126, 14, -2);
    issue(6'd16, 4'd1, 127, 0, 0, 0);
    issue(6'd40, 4'd7, -90, -90, -5, -5);
    issue(6'd5, 4'd10, 60, 112, 8, 4);
    @(negedge CLK);
    start_i = 1;
    theta_i = 6'd63;
    mag_i = 4'd15;
    @(negedge CLK);
    start_i = 0;
    wait_idle();
    repeat (3) @(negedge CLK);
    chk("hold_vx", vx_o, 8);
    chk("hold_cos", cos_o, 112);
    for (int k = 0; k < 4; k++) begin
      wait_idle();
      start_i = 1;
      case (k)
        0: begin theta_i = 6'd60; mag_i = 4'd3; push(-49, 117, 2, -2); end
        1: begin theta_i = 6'd0; mag_i = 4'd15; push(0, 127, 14, 0); end
        2: begin theta_i = 6'd8; mag_i = 4'd8; push(90, 90, 5, 5); end
        default: begin theta_i = 6'd48; mag_i = 4'd15; push(-127, 0, 0, -15); end
      endcase
      if (k > 0) chk("period", cyc + 1 - prev, 6);
      prev = cyc + 1;
    end
    @(negedge CLK);
    start_i = 0;
    issue(6'd60, 4'd3, -49, 117, 2, -2);
    wait_idle();
    start_i = 1;
    theta_i = 6'd20;
    mag_i = 4'd9;
    @(posedge CLK);
    #1;
    start_i = 0;
    repeat (2) @(negedge CLK);
    RST_N = 0;
    start_i = 1;
    @(negedge CLK);
    chk_zero("abort");
    repeat (2) @(negedge CLK);
    chk("rst_start_busy", int'(busy_o), 0);
    RST_N = 1;
    start_i = 0;
    issue(6'd40, 4'd7, -90, -90, -5, -5);
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
